// File: rtl/product_accumulator_if.sv
// Handshake bundle between the array multiplier and the product accumulator:
// product input stream, block result stream, abort and progress count.
interface product_accumulator_if #(
  parameter int PW    = 6,
  parameter int AW    = 8,
  parameter int COUNT = 4
);
  localparam int CW = $clog2(COUNT + 1);

  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_p;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;
  logic [CW-1:0] count;

  modport master (
    output clear, in_valid, in_p, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, count
  );

  modport slave (
    input  clear, in_valid, in_p, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, count
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT unsigned products into a saturating accumulator and presents the
// block total (with a sticky saturation flag) on a registered valid/ready output.
module product_accumulator #(
  parameter int PW    = 6,
  parameter int COUNT = 4,
  parameter int AW    = 8
) (
  input logic                clk,
  input logic                rst_n,
  product_accumulator_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [AW-1:0] ACC_MAX = '1;

  typedef enum logic {ACC, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_valid_q, out_valid_d;

  logic [AW:0]   sum_wide;
  logic [AW-1:0] sum_sat;
  logic          sum_ovf;
  logic          accept;
  logic          last_beat;

  // One spare bit catches the carry; the accumulator never exceeds 2^AW-1,
  // so a set top bit means exactly that this beat saturated.
  assign sum_wide  = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, bus.in_p};
  assign sum_ovf   = sum_wide[AW];
  assign sum_sat   = sum_ovf ? ACC_MAX : sum_wide[AW-1:0];
  assign accept    = (state_q == ACC) && bus.in_valid;
  assign last_beat = (count_q == CW'(COUNT - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d   = sum_sat;
          ovf_d   = ovf_q | sum_ovf;
          count_d = count_q + CW'(1);
          if (last_beat) begin
            state_d     = DONE;
            out_sum_d   = sum_sat;
            out_ovf_d   = ovf_q | sum_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = ACC;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase

    // Abort wins over any accept or result handshake on the same edge.
    if (bus.clear) begin
      state_d     = ACC;
      acc_d       = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      out_sum_d   = '0;
      out_ovf_d   = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Drives an AW=8 and an AW=7 accumulator with the same product stream and
// checks both against a block-level reference model through a result queue.
module tb_product_accumulator;
  localparam int PW    = 6;
  localparam int COUNT = 4;

  typedef struct {
    int sum8;
    bit ovf8;
    int sum7;
    bit ovf7;
  } exp_t;

  logic clk;
  logic rst_n;

  product_accumulator_if #(.PW(PW), .AW(8), .COUNT(COUNT)) if_a ();
  product_accumulator_if #(.PW(PW), .AW(7), .COUNT(COUNT)) if_b ();

  product_accumulator #(.PW(PW), .COUNT(COUNT), .AW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  product_accumulator #(.PW(PW), .COUNT(COUNT), .AW(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  int   m_beats[$];
  bit   m_done   = 1'b0;
  bit   mon_en   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit v, input int p, input bit clr, input bit rdy);
    @(posedge clk);
    #1;
    if_a.in_valid  = v;  if_b.in_valid  = v;
    if_a.clear     = clr; if_b.clear    = clr;
    if_a.out_ready = rdy; if_b.out_ready = rdy;
    if (v) begin
      if_a.in_p = PW'(p); if_b.in_p = PW'(p);
    end else begin
      if_a.in_p = 'x; if_b.in_p = 'x;
    end
  endtask

  // Reference: a block is the list of accepted products; its result is the
  // plain total clipped to the accumulator range, flagged if clipping occurred.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_beats.delete(); m_done = 1'b0; exp_q.delete();
    end else if (if_a.clear) begin
      m_beats.delete(); m_done = 1'b0; exp_q.delete();
    end else if (m_done) begin
      if (if_a.out_ready) begin
        m_done = 1'b0; m_beats.delete();
      end
    end else if (if_a.in_valid) begin
      m_beats.push_back(int'(if_a.in_p));
      if (m_beats.size() == COUNT) begin
        int   tot;
        exp_t e;
        tot = 0;
        foreach (m_beats[i]) tot += m_beats[i];
        e.sum8 = (tot > 255) ? 255 : tot;
        e.ovf8 = (tot > 255);
        e.sum7 = (tot > 127) ? 127 : tot;
        e.ovf7 = (tot > 127);
        exp_q.push_back(e);
        m_done = 1'b1;
      end
    end
  end

  // Monitor: checks handshake status every cycle and the result whenever presented.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      checkOutput("in_ready_a", int'(if_a.in_ready), int'(!m_done));
      checkOutput("in_ready_b", int'(if_b.in_ready), int'(!m_done));
      checkOutput("out_valid_a", int'(if_a.out_valid), int'(m_done));
      checkOutput("out_valid_b", int'(if_b.out_valid), int'(m_done));
      checkOutput("count_a", int'(if_a.count), m_beats.size());
      if (if_a.out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("result_expected", 0, 1);
        end else begin
          checkOutput("out_sum_a", int'(if_a.out_sum), exp_q[0].sum8);
          checkOutput("out_ovf_a", int'(if_a.out_ovf), int'(exp_q[0].ovf8));
          checkOutput("out_sum_b", int'(if_b.out_sum), exp_q[0].sum7);
          checkOutput("out_ovf_b", int'(if_b.out_ovf), int'(exp_q[0].ovf7));
          if (if_a.out_ready && !if_a.clear) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, int'(if_a.out_valid), 0);
    checkOutput({tag, "_out_sum_a"}, int'(if_a.out_sum), 0);
    checkOutput({tag, "_out_sum_b"}, int'(if_b.out_sum), 0);
    checkOutput({tag, "_out_ovf"}, int'(if_a.out_ovf), 0);
    checkOutput({tag, "_count"}, int'(if_a.count), 0);
    checkOutput({tag, "_in_ready"}, int'(if_a.in_ready), 1);
  endtask

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    if_a.in_valid = 1'b0; if_b.in_valid = 1'b0;
    if_a.clear = 1'b0; if_b.clear = 1'b0;
    if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
    if_a.in_p = '0; if_b.in_p = '0;
    #12;
    checkResetValues("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Plain block of 30s, downstream always ready.
    for (int i = 0; i < 4; i++) applyStimulus(1, 30, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Gapped beats, then the result stalls for five cycles.
    begin
      int gp[4] = '{6, 5, 49, 35};
      foreach (gp[i]) begin
        applyStimulus(1, gp[i], 0, 0);
        if (i < 3) begin
          applyStimulus(0, 0, 0, 0);
          applyStimulus(0, 0, 0, 0);
        end
      end
    end
    for (int i = 0; i < 5; i++) applyStimulus(1, 7, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);

    // Saturating block for the narrow accumulator, then a clean block.
    applyStimulus(1, 63, 0, 1);
    applyStimulus(1, 63, 0, 1);
    applyStimulus(1, 63, 0, 1);
    applyStimulus(1, 1, 0, 1);
    for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Abort after two beats; the beat presented with clear is dropped.
    applyStimulus(1, 20, 0, 1);
    applyStimulus(1, 20, 0, 1);
    applyStimulus(1, 10, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);

    // Asynchronous reset while a result is waiting.
    for (int i = 0; i < 4; i++) applyStimulus(1, 30, 0, 0);
    applyStimulus(0, 0, 0, 0);
    wait_cycles = 0;
    while (!if_a.out_valid && wait_cycles < 10) begin
      applyStimulus(0, 0, 0, 0);
      wait_cycles++;
    end
    checkOutput("done_before_reset", int'(wait_cycles < 10), 1);
    checkOutput("held_sum_before_reset", int'(if_a.out_sum), 120);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b1;

    // Randomized traffic with rare aborts and a bias toward large products.
    for (int i = 0; i < 800; i++) begin
      int p;
      p = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 9) < 7, p, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
    @(negedge clk);
    checkOutput("results_drained", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
